switch_input_controller: RTL and testbench

- Memory-mapped controller that sequences the board switch/LED resource for the MIPS CPU.
- Synchronizes and debounces the "enter" switch, and latches the data switches on each confirmed enter press.
- Exposes a valid/overrun handshake so software (e.g. case-selection test programs) can poll for operand entry.
- Owns the 24-bit LED output register written by the CPU; sits between the board pins and the CPU IO bus decode.

---
 rtl/io_map_pkg.sv | 29 ++
 rtl/switch_debouncer.sv | 58 +++++
 rtl/switch_input_controller.sv | 172 +++++++++++++++++
 tb/tb_switch_input_controller.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_map_pkg.sv
// Shared IO-map constants and FSM state type for the switch/LED block.
// Bit indices cover the optional SWITCH_IRQ_EN interrupt-enable field.
package io_map_pkg;

  localparam logic [3:0] IO_SW_DATA   = 4'h0;
  localparam logic [3:0] IO_SW_STATUS = 4'h4;
  localparam logic [3:0] IO_LED       = 4'h8;
  localparam logic [3:0] IO_SW_CTRL   = 4'hC;

  localparam int unsigned ST_VALID    = 0;
  localparam int unsigned ST_OVERRUN  = 1;
  localparam int unsigned ST_STABLE   = 2;
  localparam int unsigned ST_IRQ_EN   = 3;
  localparam int unsigned ST_CASE_LSB = 8;

  localparam int unsigned CTRL_CLR_VALID   = 0;
  localparam int unsigned CTRL_CLR_OVERRUN = 1;
  localparam int unsigned CTRL_IRQ_EN      = 2;

  localparam int unsigned SW_WIDTH  = 24;
  localparam int unsigned BUS_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    HELD    = 2'd2
  } sw_state_t;

endpackage

// File: rtl/switch_debouncer.sv
// Two-flop synchronizer for all switches plus a stability counter on the
// enter bit; emits the debounced level and single-cycle edge strobes.
module switch_debouncer
  import io_map_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 20,
  parameter int unsigned ENTER_BIT       = 20
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [SW_WIDTH-1:0] i_sw_raw,
  output logic [SW_WIDTH-1:0] o_sw_s,
  output logic                o_stable,
  output logic                o_rise_c,
  output logic                o_fall_c
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SW_WIDTH-1:0] r_sync1;
  logic [SW_WIDTH-1:0] r_sync2;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_stable;
  logic                w_mismatch;
  logic                w_toggle;

  assign w_mismatch = r_sync2[ENTER_BIT] ^ r_stable;
  assign w_toggle   = w_mismatch && (r_cnt == CNT_LAST);

  // The counter only advances while the synchronized bit disagrees with the
  // accepted level; any agreement restarts the stability window.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_cnt    <= '0;
      r_stable <= 1'b0;
    end else begin
      r_sync1 <= i_sw_raw;
      r_sync2 <= r_sync1;
      if (w_toggle) begin
        r_stable <= ~r_stable;
        r_cnt    <= '0;
      end else if (w_mismatch) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_sw_s   = r_sync2;
  assign o_stable = r_stable;
  assign o_rise_c = w_toggle & ~r_stable;
  assign o_fall_c = w_toggle &  r_stable;

endmodule

// File: rtl/switch_input_controller.sv
// Memory-mapped switch entry and LED register block for the CPU IO bus.
// Optional macro SWITCH_IRQ_EN adds the irq output and CTRL/STATUS irq_en bit.
module switch_input_controller
  import io_map_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 20,
  parameter int unsigned ENTER_BIT       = 20,
  parameter int unsigned DATA_WIDTH      = 16,
  parameter int unsigned CASE_LSB        = 21
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [SW_WIDTH-1:0]  switches_in,
  input  logic                 io_sel,
  input  logic [3:0]           io_offset,
  input  logic                 io_read,
  input  logic                 io_write,
  input  logic [BUS_WIDTH-1:0] write_data,
  output logic [BUS_WIDTH-1:0] read_data,
`ifdef SWITCH_IRQ_EN
  output logic                 irq,
`endif
  output logic [SW_WIDTH-1:0]  lights_out
);

  logic [SW_WIDTH-1:0]   w_sw_s;
  logic                  w_stable;
  logic                  w_rise_c;
  logic                  w_fall_c;

  sw_state_t             r_state;
  sw_state_t             w_state_nxt;
  logic                  w_capture;

  logic [DATA_WIDTH-1:0] r_data;
  logic [2:0]            r_case;
  logic                  r_valid;
  logic                  r_overrun;
  logic [SW_WIDTH-1:0]   r_lights;
  logic                  w_irq_en;

  logic                  w_rd;
  logic                  w_wr;
  logic                  w_rd_data;
  logic                  w_wr_led;
  logic                  w_wr_ctrl;
  logic                  w_clr_valid;
  logic                  w_clr_ovr;
  logic [BUS_WIDTH-1:0]  w_status;
  logic [BUS_WIDTH-1:0]  w_rd_mux;
  logic                  w_unused;

  switch_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .ENTER_BIT       (ENTER_BIT)
  ) u_debouncer (
    .clock    (clock),
    .reset    (reset),
    .i_sw_raw (switches_in),
    .o_sw_s   (w_sw_s),
    .o_stable (w_stable),
    .o_rise_c (w_rise_c),
    .o_fall_c (w_fall_c)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Leaving HELD also on a low level guards against a release landing in CAPTURE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_rise_c) w_state_nxt = CAPTURE;
      CAPTURE: w_state_nxt = HELD;
      HELD:    if (w_fall_c || !w_stable) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_capture = 1'b0;
    if (r_state == CAPTURE) w_capture = 1'b1;
  end

  assign w_rd      = io_sel & io_read;
  assign w_wr      = io_sel & io_write;
  assign w_rd_data = w_rd && (io_offset == IO_SW_DATA);
  assign w_wr_led  = w_wr && (io_offset == IO_LED);
  assign w_wr_ctrl = w_wr && (io_offset == IO_SW_CTRL);

  assign w_clr_valid = w_rd_data | (w_wr_ctrl & write_data[CTRL_CLR_VALID]);
  assign w_clr_ovr   = w_wr_ctrl & write_data[CTRL_CLR_OVERRUN];

  // A capture always wins over a clear of valid; overrun only when the
  // previous operand is still unread after this cycle's clears.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_data    <= '0;
      r_case    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
      r_lights  <= '0;
    end else begin
      if (w_capture) begin
        r_data <= w_sw_s[DATA_WIDTH-1:0];
        r_case <= w_sw_s[CASE_LSB+2:CASE_LSB];
      end
      if (w_capture) begin
        r_valid <= 1'b1;
      end else if (w_clr_valid) begin
        r_valid <= 1'b0;
      end
      if (w_capture && r_valid && !w_clr_valid) begin
        r_overrun <= 1'b1;
      end else if (w_clr_ovr) begin
        r_overrun <= 1'b0;
      end
      if (w_wr_led) begin
        r_lights <= write_data[SW_WIDTH-1:0];
      end
    end
  end

`ifdef SWITCH_IRQ_EN
  logic r_irq_en;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_irq_en <= 1'b0;
    end else if (w_wr_ctrl) begin
      r_irq_en <= write_data[CTRL_IRQ_EN];
    end
  end

  assign w_irq_en = r_irq_en;
  assign irq      = r_valid & r_irq_en;
`else
  assign w_irq_en = 1'b0;
`endif

  always_comb begin
    w_status                        = '0;
    w_status[ST_VALID]              = r_valid;
    w_status[ST_OVERRUN]            = r_overrun;
    w_status[ST_STABLE]             = w_stable;
    w_status[ST_IRQ_EN]             = w_irq_en;
    w_status[ST_CASE_LSB +: 3]      = r_case;
  end

  always_comb begin
    w_rd_mux = '0;
    if (w_rd && !reset) begin
      case (io_offset)
        IO_SW_DATA:   w_rd_mux = BUS_WIDTH'(r_data);
        IO_SW_STATUS: w_rd_mux = w_status;
        IO_LED:       w_rd_mux = BUS_WIDTH'(r_lights);
        default:      w_rd_mux = '0;
      endcase
    end
  end

  assign read_data  = w_rd_mux;
  assign lights_out = r_lights;

  assign w_unused = ^{write_data[BUS_WIDTH-1:SW_WIDTH], w_sw_s};

endmodule

// File: tb/tb_switch_input_controller.sv
// Scoreboarded random test of switch_input_controller against a press-level model.
module tb_switch_input_controller;
  import io_map_pkg::*;

  localparam int unsigned DB = 4;
  localparam int unsigned EB = 20;

  logic        clock = 1'b0;
  logic        reset;
  logic [23:0] switches_in;
  logic        io_sel;
  logic [3:0]  io_offset;
  logic        io_read;
  logic        io_write;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic [23:0] lights_out;
`ifdef SWITCH_IRQ_EN
  logic        irq;
`endif

  always #5 clock = ~clock;

  switch_input_controller #(
    .DEBOUNCE_CYCLES (DB),
    .ENTER_BIT       (EB),
    .DATA_WIDTH      (16),
    .CASE_LSB        (21)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .switches_in (switches_in),
    .io_sel      (io_sel),
    .io_offset   (io_offset),
    .io_read     (io_read),
    .io_write    (io_write),
    .write_data  (write_data),
    .read_data   (read_data),
`ifdef SWITCH_IRQ_EN
    .irq         (irq),
`endif
    .lights_out  (lights_out)
  );

  // Model: one entry per accepted press, no cycle-level state.
  logic        m_valid, m_ovr, m_stable, m_irq_en;
  logic [15:0] m_data;
  logic [2:0]  m_case;
  logic [23:0] m_lights;

  int          n_checks = 0;
  int          n_errors = 0;
  logic        poll = 1'b0;
  logic [31:0] q_exp[$];
  string       q_name[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] m_status();
    logic ie;
`ifdef SWITCH_IRQ_EN
    ie = m_irq_en;
`else
    ie = 1'b0;
`endif
    return {21'b0, m_case, 4'b0, ie, m_stable, m_ovr, m_valid};
  endfunction

  function automatic logic [31:0] m_read(input logic [3:0] off);
    case (off)
      IO_SW_DATA:   return {16'b0, m_data};
      IO_SW_STATUS: return m_status();
      IO_LED:       return {8'b0, m_lights};
      default:      return 32'b0;
    endcase
  endfunction

  task automatic m_reset();
    m_valid = 0; m_ovr = 0; m_stable = 0; m_irq_en = 0;
    m_data = '0; m_case = '0; m_lights = '0;
  endtask

  task automatic m_press(input logic [23:0] sw, input logic cleared);
    if (m_valid && !cleared) m_ovr = 1'b1;
    m_valid = 1'b1; m_data = sw[15:0]; m_case = sw[23:21]; m_stable = 1'b1;
  endtask

  task automatic m_write(input logic [3:0] off, input logic [31:0] d);
    if (off == IO_LED) m_lights = d[23:0];
    if (off == IO_SW_CTRL) begin
      if (d[0]) m_valid = 1'b0;
      if (d[1]) m_ovr = 1'b0;
`ifdef SWITCH_IRQ_EN
      m_irq_en = d[2];
`endif
    end
  endtask

  // Monitor: every scoreboarded read is compared at the opposite clock edge.
  always @(negedge clock) begin
    if (reset === 1'b0 && io_sel && io_read && !poll) begin
      if (q_exp.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_unexpected: read of %h with empty scoreboard", read_data);
      end else begin
        check(q_name.pop_front(), read_data, q_exp.pop_front());
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic bus_idle();
    io_sel = 0; io_read = 0; io_write = 0; io_offset = '0; write_data = '0;
  endtask

  task automatic rd(input logic [3:0] off, input string nm);
    q_exp.push_back(m_read(off));
    q_name.push_back(nm);
    io_sel = 1; io_read = 1; io_offset = off;
    cyc();
    bus_idle();
    if (off == IO_SW_DATA) m_valid = 1'b0;
  endtask

  task automatic wr(input logic [3:0] off, input logic [31:0] d);
    io_sel = 1; io_write = 1; io_offset = off; write_data = d;
    cyc();
    bus_idle();
    m_write(off, d);
  endtask

  task automatic rdwr(input logic [3:0] off, input logic [31:0] d, input string nm);
    q_exp.push_back(m_read(off));
    q_name.push_back(nm);
    io_sel = 1; io_read = 1; io_write = 1; io_offset = off; write_data = d;
    cyc();
    bus_idle();
    if (off == IO_SW_DATA) m_valid = 1'b0;
    m_write(off, d);
  endtask

  task automatic press(input logic [23:0] sw);
    switches_in = sw | 24'h100000;
    m_press(switches_in, 1'b0);
    repeat (12) cyc();
  endtask

  task automatic release_enter();
    switches_in[EB] = 1'b0;
    repeat (12) cyc();
    m_stable = 1'b0;
  endtask

  // Polls STATUS outside the scoreboard until enter_stable rises; returns cycles waited.
  task automatic wait_stable(output int k);
    poll = 1; io_sel = 1; io_read = 1; io_offset = IO_SW_STATUS;
    k = 0;
    while (k < 20) begin
      cyc();
      k++;
      if (read_data[ST_STABLE]) break;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          k;
    int          op;
    logic [31:0] d;

    reset = 1; switches_in = '0; bus_idle(); m_reset();
    repeat (2) @(posedge clock);
    #1;
    poll = 1; io_sel = 1; io_read = 1; io_offset = IO_SW_STATUS;
    #1;
    check("reset_read", read_data, 32'h0);
    check("reset_leds", {8'b0, lights_out}, 32'h0);
    bus_idle(); poll = 0;
    reset = 0;
    cyc();

    wr(IO_LED, 32'h00ABCDEF);
    check("led_write", {8'b0, lights_out}, {8'b0, m_lights});
    rd(IO_LED, "led_read");

    // Reset mid-debounce with every switch high.
    switches_in = 24'hFFFFFF;
    repeat (3) cyc();
    #3 reset = 1;
    m_reset();
    poll = 1; io_sel = 1; io_read = 1; io_offset = IO_LED;
    #1;
    check("midreset_read", read_data, 32'h0);
    check("midreset_leds", {8'b0, lights_out}, 32'h0);
    bus_idle(); poll = 0;
    cyc();
    reset = 0;
    wait_stable(k);
    check("reset_press_latency", 32'(k), 32'(DB + 2));
    bus_idle(); poll = 0;
    m_press(24'hFFFFFF, 1'b0);
    repeat (3) cyc();
    rd(IO_SW_STATUS, "reset_press_status");
    rd(IO_SW_DATA, "reset_press_data");
    rd(IO_SW_STATUS, "reset_press_status2");
    release_enter();

    // Bounce faster than the debounce window.
    switches_in = 24'h000001;
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) switches_in[EB] = ~switches_in[EB];
      rd(IO_SW_STATUS, "bounce_status");
    end
    switches_in[EB] = 1'b0;
    repeat (8) cyc();
    rd(IO_SW_STATUS, "bounce_after");

    // Basic entry.
    press(24'h000001);
    rd(IO_SW_STATUS, "basic_status");
    rd(IO_SW_DATA, "basic_data");
    rd(IO_SW_STATUS, "basic_status2");
    release_enter();

    // Overrun.
    press(24'h100003); release_enter();
    press(24'h300005); release_enter();
    rd(IO_SW_STATUS, "ovr_status");
    rd(IO_SW_DATA, "ovr_data");
    rd(IO_SW_STATUS, "ovr_status2");
    wr(IO_SW_CTRL, 32'h2);
    rd(IO_SW_STATUS, "ovr_cleared");

    // DATA read in the CAPTURE cycle while valid is already set.
    press(24'h000007); release_enter();
    switches_in = 24'h50000A;
    wait_stable(k);
    check("race_latency", 32'(k), 32'(DB + 2));
    poll = 0;
    io_offset = IO_SW_DATA;
    q_exp.push_back(m_read(IO_SW_DATA));
    q_name.push_back("race_data_old");
    cyc();
    bus_idle();
    m_press(24'h50000A, 1'b1);
    rd(IO_SW_STATUS, "race_status");
    rd(IO_SW_DATA, "race_data_new");
    release_enter();

`ifdef SWITCH_IRQ_EN
    wr(IO_SW_CTRL, 32'h4);
    check("irq_idle", {31'b0, irq}, 32'h0);
    press(24'h00BEEF);
    check("irq_set", {31'b0, irq}, 32'h1);
    release_enter();
    rd(IO_SW_DATA, "irq_data");
    check("irq_cleared", {31'b0, irq}, 32'h0);
`endif

    for (int n = 0; n < 60; n++) begin
      op = int'($urandom_range(0, 8));
      d  = $urandom;
      case (op)
        0: begin press(24'(d)); release_enter(); end
        1: rd(IO_SW_DATA, "rnd_data");
        2: rd(IO_SW_STATUS, "rnd_status");
        3: wr(IO_SW_CTRL, {29'b0, d[2:0]});
        4: wr(IO_LED, d);
        5: rd(IO_LED, "rnd_led");
        6: rdwr(IO_LED, d, "rnd_led_rdwr");
        7: rd(IO_SW_CTRL, "rnd_ctrl_read");
        default: begin
          wr(d[0] ? IO_SW_STATUS : IO_SW_DATA, d);
          rd(IO_SW_STATUS, "rnd_ignored_wr");
        end
      endcase
      check("rnd_lights", {8'b0, lights_out}, {8'b0, m_lights});
`ifdef SWITCH_IRQ_EN
      check("rnd_irq", {31'b0, irq}, {31'b0, m_valid & m_irq_en});
`endif
    end

    repeat (2) cyc();
    check("sb_drain", 32'(q_exp.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
